sm2201_camac_read_sequencer: RTL and testbench

- Sits directly downstream of the ISA-side register decode in the sm2201 ISA–CAMAC interface board.
- On a start pulse, runs one CAMAC dataway read cycle: drives N/A/F onto cb_addr, strobes cb_cx1, waits for module response cb_prr, latches the 16-bit cb_data word.
- Presents the latched word to the ISA data port as two bytes, inserting ISA wait states (isa_chrdy low) when the port is read mid-cycle.

---
 rtl/sm2201_camac_read_sequencer.sv | 123 ++++++++++++
 tb/tb_sm2201_camac_read_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sm2201_camac_read_sequencer.sv
// CAMAC dataway read sequencer for the sm2201 ISA-CAMAC board: one N/A/F read
// cycle per start pulse, with the captured word served to ISA as two bytes.
module sm2201_camac_read_sequencer #(
    parameter int SETTLE_CYCLES  = 2,
    parameter int STROBE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        isa_clk,
    input  logic        isa_reset,
    input  logic        start,
    input  logic [11:0] cmd_addr,
    input  logic        byte_sel,
    input  logic        rd_strobe,
    output logic [7:0]  rd_data,
    output logic        busy,
    output logic        data_valid,
    output logic        cycle_err,
    output logic        isa_chrdy,
    output logic [11:0] cb_addr,
    output logic        cb_cx1,
    input  logic        cb_prr,
    input  logic        cb_zk4,
    input  logic [15:0] cb_data_in
);
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] STROBE_LAST  = CW'(STROBE_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SETUP   = 2'd1;
    localparam logic [1:0] S_STROBE  = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [11:0]   addr_q, addr_d;
    logic [15:0]   data_q, data_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic          chrdy_q, chrdy_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        valid_d = valid_q;
        err_d   = err_q;
        chrdy_d = chrdy_q;
        case (state_q)
            S_IDLE: begin
                // A high-byte read completes the word; the accept below still wins.
                if (rd_strobe && byte_sel) valid_d = 1'b0;
                if (start && cb_zk4) begin
                    addr_d  = cmd_addr;
                    valid_d = 1'b0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (!cb_zk4) begin
                    err_d   = 1'b1;
                    state_d = S_RELEASE;
                end else if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = S_STROBE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STROBE: begin
                if (!cb_zk4) begin
                    err_d   = 1'b1;
                    state_d = S_RELEASE;
                end else if (cnt_q >= STROBE_LAST && !cb_prr) begin
                    data_d  = cb_data_in;
                    valid_d = 1'b1;
                    state_d = S_RELEASE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_RELEASE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        // ISA wait state: held from a mid-cycle read until the edge back into IDLE.
        if (state_q == S_RELEASE) chrdy_d = 1'b1;
        else if (state_q != S_IDLE && rd_strobe) chrdy_d = 1'b0;
    end

    always_ff @(posedge isa_clk) begin
        if (isa_reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            chrdy_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            chrdy_q <= chrdy_d;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign cb_cx1     = (state_q != S_STROBE);
    assign cb_addr    = addr_q;
    assign data_valid = valid_q;
    assign cycle_err  = err_q;
    assign isa_chrdy  = chrdy_q;
    assign rd_data    = byte_sel ? data_q[15:8] : data_q[7:0];
endmodule

// File: tb/tb_sm2201_camac_read_sequencer.sv
// Scoreboard bench for the CAMAC read sequencer: expected cycle results are
// queued at start and checked when busy drops.
module tb_sm2201_camac_read_sequencer;
    logic        isa_clk = 1'b0;
    logic        isa_reset = 1'b1;
    logic        start = 1'b0;
    logic [11:0] cmd_addr = '0;
    logic        byte_sel = 1'b0;
    logic        rd_strobe = 1'b0;
    logic        cb_zk4 = 1'b1;
    logic [15:0] cb_data_in = '0;
    logic        cb_prr;
    logic [7:0]  rd_data;
    logic        busy, data_valid, cycle_err, isa_chrdy, cb_cx1;
    logic [11:0] cb_addr;

    int prr_mode = 0;   // 0: prr held low, 1: low from 10th strobe clock, 2: never
    int strobe_n = 0;
    int n_chk = 0;
    int n_fail = 0;
    logic [15:0] last_data = '0;

    typedef struct {
        int cx1_low;
        int busy_len;
        int data;
        int err;
        int valid;
    } exp_t;
    exp_t sb[$];

    sm2201_camac_read_sequencer dut (
        .isa_clk(isa_clk), .isa_reset(isa_reset), .start(start), .cmd_addr(cmd_addr),
        .byte_sel(byte_sel), .rd_strobe(rd_strobe), .rd_data(rd_data), .busy(busy),
        .data_valid(data_valid), .cycle_err(cycle_err), .isa_chrdy(isa_chrdy),
        .cb_addr(cb_addr), .cb_cx1(cb_cx1), .cb_prr(cb_prr), .cb_zk4(cb_zk4),
        .cb_data_in(cb_data_in)
    );

    always #5 isa_clk = ~isa_clk;
    always @(posedge isa_clk) strobe_n <= cb_cx1 ? 0 : strobe_n + 1;
    assign cb_prr = (prr_mode == 0) ? 1'b0 : (prr_mode == 1) ? (strobe_n < 10) : 1'b1;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_cycle(input logic [11:0] addr, input int rd_at, input int inh_at,
                            input bit rd_with_start);
        exp_t e;
        int busy_n = 0;
        int low_n = 0;
        int lo_n = 0;
        start = 1'b1;
        cmd_addr = addr;
        if (rd_with_start) begin
            rd_strobe = 1'b1;
            byte_sel = 1'b1;
            #1 chk("rd_old_with_start", int'(rd_data), int'(last_data[15:8]));
        end
        @(negedge isa_clk);
        start = 1'b0;
        rd_strobe = 1'b0;
        byte_sel = 1'b0;
        cmd_addr = 12'hFFF;
        chk("accept_addr", int'(cb_addr), int'(addr));
        if (rd_with_start) chk("valid_clr_on_start", int'(data_valid), 0);
        for (int i = 0; i < 200 && busy; i++) begin
            busy_n++;
            if (!cb_cx1) low_n++;
            if (rd_at >= 0 && i > rd_at && !isa_chrdy) lo_n++;
            rd_strobe = (i == rd_at);
            start = (i == rd_at);
            if (low_n == inh_at) cb_zk4 = 1'b0;
            @(negedge isa_clk);
        end
        rd_strobe = 1'b0;
        start = 1'b0;
        cb_zk4 = 1'b1;
        chk("done_in_budget", int'(busy), 0);
        e = sb.pop_front();
        chk("cx1_low_clocks", low_n, e.cx1_low);
        chk("busy_clocks", busy_n, e.busy_len);
        chk("cycle_err", int'(cycle_err), e.err);
        chk("data_valid", int'(data_valid), e.valid);
        chk("addr_held", int'(cb_addr), int'(addr));
        if (rd_at >= 0) begin
            chk("chrdy_wait_clocks", lo_n, e.busy_len - rd_at - 1);
            chk("chrdy_back", int'(isa_chrdy), 1);
            repeat (2) @(negedge isa_clk);
            chk("no_second_cycle", int'(busy), 0);
        end
        #1 chk("rd_lo", int'(rd_data), e.data & 'hff);
        byte_sel = 1'b1;
        #1 chk("rd_hi", int'(rd_data), (e.data >> 8) & 'hff);
        byte_sel = 1'b0;
        last_data = 16'(e.data);
    endtask

    initial begin
        repeat (3) @(negedge isa_clk);
        isa_reset = 1'b0;
        chk("rst_cx1", int'(cb_cx1), 1);
        chk("rst_addr", int'(cb_addr), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(data_valid), 0);
        chk("rst_err", int'(cycle_err), 0);
        chk("rst_chrdy", int'(isa_chrdy), 1);
        chk("rst_rd_data", int'(rd_data), 0);

        // Response already present: minimum-length cycle.
        prr_mode = 0; cb_data_in = 16'h1234;
        sb.push_back(exp_t'{4, 7, 'h1234, 0, 1});
        do_cycle(12'hA53, -1, -1, 1'b0);
        rd_strobe = 1'b1; byte_sel = 1'b0;
        @(negedge isa_clk);
        rd_strobe = 1'b0;
        chk("valid_after_lo_read", int'(data_valid), 1);
        rd_strobe = 1'b1; byte_sel = 1'b1;
        #1 chk("rd_hi_strobe", int'(rd_data), 'h12);
        @(negedge isa_clk);
        rd_strobe = 1'b0; byte_sel = 1'b0;
        chk("valid_after_hi_read", int'(data_valid), 0);

        // Late response.
        prr_mode = 1; cb_data_in = 16'hBEEF;
        sb.push_back(exp_t'{11, 14, 'hBEEF, 0, 1});
        do_cycle(12'h111, -1, -1, 1'b0);

        // No response: timeout, data kept; also start+read in the same IDLE cycle.
        prr_mode = 2; cb_data_in = 16'hDEAD;
        sb.push_back(exp_t'{64, 67, 'hBEEF, 1, 0});
        do_cycle(12'h222, -1, -1, 1'b1);

        // Mid-cycle read inserts wait states; extra start ignored.
        prr_mode = 0; cb_data_in = 16'h5A5A;
        sb.push_back(exp_t'{4, 7, 'h5A5A, 0, 1});
        do_cycle(12'h333, 2, -1, 1'b0);

        // Inhibit after 3 strobe clocks.
        cb_data_in = 16'hCAFE;
        sb.push_back(exp_t'{3, 6, 'h5A5A, 1, 0});
        do_cycle(12'h444, -1, 3, 1'b0);

        cb_zk4 = 1'b0; start = 1'b1; cmd_addr = 12'h777;
        @(negedge isa_clk);
        start = 1'b0;
        chk("inhibited_start_busy", int'(busy), 0);
        chk("inhibited_start_err", int'(cycle_err), 1);
        chk("inhibited_start_addr", int'(cb_addr), 'h444);
        cb_zk4 = 1'b1;

        // Reset in the middle of a strobe.
        prr_mode = 2; start = 1'b1; cmd_addr = 12'h555;
        @(negedge isa_clk);
        start = 1'b0;
        for (int i = 0; i < 20 && cb_cx1; i++) @(negedge isa_clk);
        chk("reached_strobe", int'(cb_cx1), 0);
        @(negedge isa_clk);
        isa_reset = 1'b1;
        @(negedge isa_clk);
        isa_reset = 1'b0;
        chk("midrst_cx1", int'(cb_cx1), 1);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_valid", int'(data_valid), 0);
        chk("midrst_err", int'(cycle_err), 0);
        chk("midrst_chrdy", int'(isa_chrdy), 1);
        chk("midrst_addr", int'(cb_addr), 0);
        chk("midrst_rd_data", int'(rd_data), 0);

        prr_mode = 0; cb_data_in = 16'h9876;
        sb.push_back(exp_t'{4, 7, 'h9876, 0, 1});
        do_cycle(12'h666, -1, -1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
